// File: rtl/hog_bridge_pkg.sv
// Shared constants for the HPS bridge controller: register map, bit positions, ID and FSM states.
package hog_bridge_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_IRQ_STAT  = 3'd2;
  localparam logic [2:0] REG_IRQ_MASK  = 3'd3;
  localparam logic [2:0] REG_PIXEL     = 3'd4;
  localparam logic [2:0] REG_FRAME_CNT = 3'd5;
  localparam logic [2:0] REG_PIXEL_CNT = 3'd6;
  localparam logic [2:0] REG_ID        = 3'd7;

  localparam int CTRL_START    = 0;
  localparam int CTRL_SOFT_RST = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int IRQ_DONE       = 0;
  localparam int IRQ_SLOT_EMPTY = 1;
  localparam int IRQ_OVF        = 2;

  localparam logic [31:0] HOG_ID = 32'h484F_4701;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RECOVER
  } state_e;

endpackage

// File: rtl/hog_pixel_slot.sv
// One-entry valid/ready slot feeding the HOG pixel input; accepts a load in the same
// cycle the held pixel is consumed.
module hog_pixel_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  flush,
  input  logic                  pixel_ready,
  output logic                  pixel_valid,
  output logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  can_accept,
  output logic                  went_empty
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && pixel_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign can_accept  = !valid_q || pixel_ready;
  assign went_empty  = valid_q && !valid_d;
  assign pixel_valid = valid_q;
  assign pixel_data  = data_q;

endmodule

// File: rtl/hog_bridge_ctrl.sv
// HPS bridge slave: register file, interrupt logic and bus handshake FSM for the HOG core,
// with PIXEL writes pushed into a one-entry slot.
module hog_bridge_ctrl
  import hog_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int BUS_WIDTH  = 32,
  parameter int BUS_BYTES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  bus_enable,
  input  logic                  r_wbar,
  input  logic [BUS_WIDTH-1:0]  write_data,
  input  logic [BUS_BYTES-1:0]  byte_enable,
  output logic [BUS_WIDTH-1:0]  read_data,
  output logic                  ack,
  output logic                  irq,
  output logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  input  logic                  hog_busy,
  input  logic                  hog_done,
  output logic                  hog_start,
  output logic                  hog_soft_rst
);

  localparam int CW = $clog2(TIMEOUT);

  state_e                state_q, state_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic [BUS_WIDTH-1:0]  rdata_q, rdata_d, rd_mux;
  logic                  start_q, start_d;
  logic                  irq_en_q, irq_en_d;
  logic                  soft_rst_q, soft_rst_d;
  logic [2:0]            irq_stat_q, irq_stat_d;
  logic [2:0]            irq_mask_q, irq_mask_d;
  logic                  done_st_q, done_st_d;
  logic                  ovf_st_q, ovf_st_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [31:0]           pixel_cnt_q, pixel_cnt_d;
  logic                  irq_q, irq_d;

  logic [2:0]            word;
  logic [2:0]            irq_clr;
  logic                  frame_clr, stat_rd, ovf_evt;
  logic                  slot_load, slot_can_accept, slot_went_empty;
  logic [DATA_WIDTH-1:0] slot_data;
  logic                  unused_bits;

  assign word        = addr[4:2];
  assign unused_bits = ^{addr[1:0], write_data[BUS_WIDTH-1:DATA_WIDTH],
                         byte_enable[BUS_BYTES-1:1]};

  always_comb begin
    case (word)
      REG_CTRL:      rd_mux = BUS_WIDTH'({irq_en_q, soft_rst_q, 1'b0});
      REG_STATUS:    rd_mux = BUS_WIDTH'({ovf_st_q, done_st_q, pixel_valid, hog_busy});
      REG_IRQ_STAT:  rd_mux = BUS_WIDTH'(irq_stat_q);
      REG_IRQ_MASK:  rd_mux = BUS_WIDTH'(irq_mask_q);
      REG_FRAME_CNT: rd_mux = BUS_WIDTH'(frame_cnt_q);
      REG_PIXEL_CNT: rd_mux = BUS_WIDTH'(pixel_cnt_q);
      REG_ID:        rd_mux = BUS_WIDTH'(HOG_ID);
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pend_d     = pend_q;
    rdata_d    = '0;
    start_d    = 1'b0;
    irq_en_d   = irq_en_q;
    soft_rst_d = soft_rst_q;
    irq_mask_d = irq_mask_q;
    irq_clr    = '0;
    frame_clr  = 1'b0;
    stat_rd    = 1'b0;
    ovf_evt    = 1'b0;
    slot_load  = 1'b0;
    slot_data  = pend_q;

    case (state_q)
      S_IDLE: begin
        if (bus_enable) begin
          state_d = S_ACK;
          if (r_wbar) begin
            rdata_d = rd_mux;
            stat_rd = (word == REG_STATUS);
          end else begin
            case (word)
              REG_CTRL: if (byte_enable[0]) begin
                start_d    = write_data[CTRL_START];
                soft_rst_d = write_data[CTRL_SOFT_RST];
                irq_en_d   = write_data[CTRL_IRQ_EN];
              end
              REG_IRQ_STAT: if (byte_enable[0]) irq_clr = write_data[2:0];
              REG_IRQ_MASK: if (byte_enable[0]) irq_mask_d = write_data[2:0];
              REG_PIXEL: if (byte_enable[0] && !soft_rst_q) begin
                slot_data = write_data[DATA_WIDTH-1:0];
                pend_d    = write_data[DATA_WIDTH-1:0];
                if (slot_can_accept) begin
                  slot_load = 1'b1;
                end else begin
                  wait_cnt_d = '0;
                  state_d    = S_WAIT;
                end
              end
              REG_FRAME_CNT: frame_clr = 1'b1;
              default: ;
            endcase
          end
        end
      end
      S_WAIT: begin
        // Soft reset flushes the slot, so a stalled pixel is dropped silently.
        if (soft_rst_q) begin
          state_d = S_ACK;
        end else if (slot_can_accept) begin
          slot_load = 1'b1;
          state_d   = S_ACK;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          ovf_evt = 1'b1;
          state_d = S_ACK;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      S_ACK:     state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Event sets are applied after clears so a coincident set always wins.
    irq_stat_d  = (irq_stat_q & ~irq_clr) | {ovf_evt, slot_went_empty, hog_done};
    done_st_d   = (done_st_q && !stat_rd) || hog_done;
    ovf_st_d    = (ovf_st_q && !stat_rd) || ovf_evt;
    frame_cnt_d = (frame_clr ? 16'd0 : frame_cnt_q) + 16'(hog_done);
    pixel_cnt_d = pixel_cnt_q + 32'(slot_load);
    irq_d       = irq_en_q && |(irq_stat_q & irq_mask_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      pend_q      <= '0;
      rdata_q     <= '0;
      start_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      soft_rst_q  <= 1'b0;
      irq_stat_q  <= '0;
      irq_mask_q  <= '0;
      done_st_q   <= 1'b0;
      ovf_st_q    <= 1'b0;
      frame_cnt_q <= '0;
      pixel_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      pend_q      <= pend_d;
      rdata_q     <= rdata_d;
      start_q     <= start_d;
      irq_en_q    <= irq_en_d;
      soft_rst_q  <= soft_rst_d;
      irq_stat_q  <= irq_stat_d;
      irq_mask_q  <= irq_mask_d;
      done_st_q   <= done_st_d;
      ovf_st_q    <= ovf_st_d;
      frame_cnt_q <= frame_cnt_d;
      pixel_cnt_q <= pixel_cnt_d;
      irq_q       <= irq_d;
    end
  end

  hog_pixel_slot #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (slot_load),
    .load_data  (slot_data),
    .flush      (soft_rst_q),
    .pixel_ready(pixel_ready),
    .pixel_valid(pixel_valid),
    .pixel_data (pixel_data),
    .can_accept (slot_can_accept),
    .went_empty (slot_went_empty)
  );

  assign ack          = (state_q == S_ACK);
  assign read_data    = rdata_q;
  assign irq          = irq_q;
  assign hog_start    = start_q;
  assign hog_soft_rst = soft_rst_q;

endmodule

// File: tb/tb_hog_bridge_ctrl.sv
// Directed bench for hog_bridge_ctrl: bus handshake, register map, pixel slot stalls,
// timeout overflow, soft reset, interrupts and reset during a stalled write.
module tb_hog_bridge_ctrl;

  localparam int TO = 16;

  localparam logic [4:0] A_CTRL  = 5'h00;
  localparam logic [4:0] A_STAT  = 5'h04;
  localparam logic [4:0] A_ISTAT = 5'h08;
  localparam logic [4:0] A_IMASK = 5'h0C;
  localparam logic [4:0] A_PIX   = 5'h10;
  localparam logic [4:0] A_FRAME = 5'h14;
  localparam logic [4:0] A_PCNT  = 5'h18;
  localparam logic [4:0] A_ID    = 5'h1C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  addr;
  logic        bus_enable;
  logic        r_wbar;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic [31:0] read_data;
  logic        ack;
  logic        irq;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        hog_busy;
  logic        hog_done;
  logic        hog_start;
  logic        hog_soft_rst;

  int         n_chk = 0;
  int         n_fail = 0;
  int         start_cnt = 0;
  logic [7:0] xfer_q[$];

  always #5 clk = ~clk;

  hog_bridge_ctrl #(
    .ADDR_WIDTH(5),
    .BUS_WIDTH (32),
    .BUS_BYTES (4),
    .DATA_WIDTH(8),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .bus_enable  (bus_enable),
    .r_wbar      (r_wbar),
    .write_data  (write_data),
    .byte_enable (byte_enable),
    .read_data   (read_data),
    .ack         (ack),
    .irq         (irq),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .hog_busy    (hog_busy),
    .hog_done    (hog_done),
    .hog_start   (hog_start),
    .hog_soft_rst(hog_soft_rst)
  );

  always @(posedge clk) begin
    if (hog_start) start_cnt <= start_cnt + 1;
    if (pixel_valid && pixel_ready) xfer_q.push_back(pixel_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_begin(input logic rw, input logic [4:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
    addr        = a;
    r_wbar      = rw;
    write_data  = wd;
    byte_enable = be;
    bus_enable  = 1'b1;
  endtask

  task automatic bus_finish(input string tag, output logic [31:0] rd, output int lat);
    lat = 0;
    while (!ack && lat < TO + 8) begin
      tick();
      lat++;
    end
    chk({tag, " ack"}, 32'(ack), 32'd1);
    rd         = read_data;
    bus_enable = 1'b0;
    r_wbar     = 1'b0;
    tick();
    chk({tag, " ack pulse"}, 32'(ack), 32'd0);
    tick();
  endtask

  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] wd,
                    input logic [3:0] be);
    logic [31:0] rd;
    int          lat;
    bus_begin(1'b0, a, wd, be);
    bus_finish(tag, rd, lat);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    bus_begin(1'b1, a, 32'h0, 4'hF);
    bus_finish(tag, rd, lat);
    chk(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        ack_seen;

    rst_n = 1'b0; addr = '0; bus_enable = 1'b0; r_wbar = 1'b0; write_data = '0;
    byte_enable = '0; pixel_ready = 1'b0; hog_busy = 1'b0; hog_done = 1'b0;
    repeat (3) tick();
    chk("reset ctl outs", 32'({ack, irq, hog_start, hog_soft_rst, pixel_valid}), 32'd0);
    chk("reset read_data", read_data, 32'h0);
    chk("reset pixel_data", 32'(pixel_data), 32'h0);
    rst_n = 1'b1;
    tick();

    // ID read: one-cycle latency, single ack pulse
    bus_begin(1'b1, A_ID, 32'h0, 4'hF);
    bus_finish("id", rd, lat);
    chk("id latency", 32'(lat), 32'd1);
    chk("id value", rd, 32'h484F_4701);

    // start pulse and byte-lane gating
    wr("ctrl start", A_CTRL, 32'h1, 4'hF);
    chk("start pulses", 32'(start_cnt), 32'd1);
    rd_chk("ctrl readback", A_CTRL, 32'h0);
    wr("ctrl start be", A_CTRL, 32'h1, 4'hE);
    chk("start gated", 32'(start_cnt), 32'd1);

    // two pixels, second stalls until ready rises
    wr("pix a5", A_PIX, 32'hA5, 4'hF);
    chk("pix a5 valid", 32'(pixel_valid), 32'd1);
    chk("pix a5 data", 32'(pixel_data), 32'hA5);
    bus_begin(1'b0, A_PIX, 32'h5A, 4'hF);
    ack_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      ack_seen = ack_seen | ack;
    end
    chk("pix stall no ack", 32'(ack_seen), 32'd0);
    pixel_ready = 1'b1;
    bus_finish("pix 5a", rd, lat);
    chk("pix 5a latency", 32'(lat), 32'd1);
    chk("pix drained", 32'(pixel_valid), 32'd0);
    chk("xfer count", 32'(xfer_q.size()), 32'd2);
    chk("xfer 0", 32'(xfer_q[0]), 32'hA5);
    chk("xfer 1", 32'(xfer_q[1]), 32'h5A);
    pixel_ready = 1'b0;
    rd_chk("pixel_cnt 2", A_PCNT, 32'd2);

    // timeout on a full slot
    wr("pix a5 again", A_PIX, 32'hA5, 4'hF);
    bus_begin(1'b0, A_PIX, 32'h77, 4'hF);
    bus_finish("pix timeout", rd, lat);
    chk("timeout latency", 32'(lat), 32'(TO + 1));
    chk("timeout data kept", 32'(pixel_data), 32'hA5);
    chk("timeout valid kept", 32'(pixel_valid), 32'd1);
    rd_chk("status ovf", A_STAT, 32'hA);
    rd_chk("irq_stat ovf", A_ISTAT, 32'h6);
    rd_chk("status ovf cleared", A_STAT, 32'h2);
    rd_chk("pixel_cnt 3", A_PCNT, 32'd3);

    // soft reset flushes the slot and drops loads
    wr("ctrl soft", A_CTRL, 32'h2, 4'hF);
    chk("soft_rst out", 32'(hog_soft_rst), 32'd1);
    chk("soft flush", 32'(pixel_valid), 32'd0);
    wr("pix during soft", A_PIX, 32'h11, 4'hF);
    chk("soft no load", 32'(pixel_valid), 32'd0);
    rd_chk("pixel_cnt soft", A_PCNT, 32'd3);
    wr("ctrl unsoft", A_CTRL, 32'h0, 4'hF);
    chk("soft_rst off", 32'(hog_soft_rst), 32'd0);

    // done interrupt
    wr("istat clr all", A_ISTAT, 32'h7, 4'hF);
    wr("imask", A_IMASK, 32'h1, 4'hF);
    wr("irq_en", A_CTRL, 32'h4, 4'hF);
    chk("irq idle", 32'(irq), 32'd0);
    hog_done = 1'b1;
    tick();
    hog_done = 1'b0;
    tick();
    chk("irq on done", 32'(irq), 32'd1);
    rd_chk("frame 1", A_FRAME, 32'd1);
    hog_busy = 1'b1;
    rd_chk("status done busy", A_STAT, 32'h5);
    hog_busy = 1'b0;
    wr("istat w1c", A_ISTAT, 32'h1, 4'hF);
    chk("irq cleared", 32'(irq), 32'd0);

    // done coincident with w1c: set wins
    bus_begin(1'b0, A_ISTAT, 32'h1, 4'hF);
    hog_done = 1'b1;
    tick();
    hog_done = 1'b0;
    bus_finish("w1c vs done", rd, lat);
    rd_chk("istat set wins", A_ISTAT, 32'h1);
    chk("irq set wins", 32'(irq), 32'd1);
    rd_chk("frame 2", A_FRAME, 32'd2);

    // done coincident with FRAME_CNT clear: increment wins
    bus_begin(1'b0, A_FRAME, 32'h0, 4'hF);
    hog_done = 1'b1;
    tick();
    hog_done = 1'b0;
    bus_finish("frame clr vs done", rd, lat);
    rd_chk("frame after clr", A_FRAME, 32'd1);

    // reset asserted while a pixel write is stalled
    wr("pix 01", A_PIX, 32'h01, 4'hF);
    bus_begin(1'b0, A_PIX, 32'h02, 4'hF);
    repeat (3) tick();
    chk("wait no ack", 32'(ack), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst valid", 32'(pixel_valid), 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    bus_enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post rst ack", 32'(ack), 32'd0);
    rd_chk("rst pixel_cnt", A_PCNT, 32'd0);
    rd_chk("rst frame", A_FRAME, 32'd0);
    rd_chk("rst imask", A_IMASK, 32'd0);
    bus_begin(1'b1, A_ID, 32'h0, 4'hF);
    bus_finish("id after rst", rd, lat);
    chk("idle after rst", 32'(lat), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
